// File: rtl/sprite_pkg.sv
// sprite_pkg: descriptor field positions, sprite geometry and rom_addr layout.
package sprite_pkg;
  localparam int N_SPRITES   = 8;
  localparam int SPRITE_SIZE = 32;
  localparam int OFF_W       = $clog2(SPRITE_SIZE);
  localparam int COORD_W     = 10;
  localparam int D_VALID = 31;
  localparam int D_FLIP  = 26;
  localparam int D_X     = 16;
  localparam int D_Y     = 6;
  localparam int D_ROW   = 3;
  localparam int D_COL   = 0;
  localparam int R_ROW = 13;
  localparam int R_COL = 10;
  localparam int R_DY  = 5;
  localparam int R_DX  = 0;
  typedef logic [31:0] desc_t;
  function automatic logic [15:0] rom_pack(logic [2:0] row, logic [2:0] col,
                                           logic [OFF_W-1:0] dy, logic [OFF_W-1:0] dx);
    logic [15:0] r;
    r = '0;
    r[R_ROW +: 3]     = row;
    r[R_COL +: 3]     = col;
    r[R_DY +: OFF_W]  = dy;
    r[R_DX +: OFF_W]  = dx;
    return r;
  endfunction
endpackage

// File: rtl/sprite_scanner_if.sv
// sprite_scanner_if: descriptor write port, raster input and pixel result bundle.
interface sprite_scanner_if;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] dina;
  logic        frame_start;
  logic        pixel_tick;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        pix_valid;
  logic        sprite_hit;
  logic [2:0]  sprite_idx;
  logic [15:0] rom_addr;
  modport master (
    output we, addr, dina, frame_start, pixel_tick, pixel_x, pixel_y, video_on,
    input  pix_valid, sprite_hit, sprite_idx, rom_addr
  );
  modport slave (
    input  we, addr, dina, frame_start, pixel_tick, pixel_x, pixel_y, video_on,
    output pix_valid, sprite_hit, sprite_idx, rom_addr
  );
endinterface

// File: rtl/sprite_hit_test.sv
// sprite_hit_test: range compare of one descriptor against the raster position plus sheet address.
module sprite_hit_test #(
  parameter int SPRITE_SIZE = sprite_pkg::SPRITE_SIZE
) (
  input  logic [31:0] i_desc,
  input  logic [9:0]  i_px,
  input  logic [9:0]  i_py,
  output logic        o_hit,
  output logic [15:0] o_rom
);
  import sprite_pkg::*;
  logic [10:0] w_x, w_y, w_px, w_py, w_dx, w_dy;
  logic [OFF_W-1:0] w_off_x;
  logic w_unused;
  assign w_x  = {1'b0, i_desc[D_X +: COORD_W]};
  assign w_y  = {1'b0, i_desc[D_Y +: COORD_W]};
  assign w_px = {1'b0, i_px};
  assign w_py = {1'b0, i_py};
  assign w_dx = w_px - w_x;
  assign w_dy = w_py - w_y;
  // 11-bit compares keep a sprite near x=1023 from wrapping onto the left edge
  assign o_hit = i_desc[D_VALID] && w_px >= w_x && w_px < w_x + 11'(SPRITE_SIZE)
                 && w_py >= w_y && w_py < w_y + 11'(SPRITE_SIZE);
  assign w_off_x = i_desc[D_FLIP] ? ~w_dx[OFF_W-1:0] : w_dx[OFF_W-1:0];
  assign o_rom = rom_pack(i_desc[D_ROW +: 3], i_desc[D_COL +: 3], w_dy[OFF_W-1:0], w_off_x);
  assign w_unused = ^{i_desc[30:27], w_dx[10:OFF_W], w_dy[10:OFF_W]};
endmodule

// File: rtl/sprite_scanner.sv
// sprite_scanner: double-buffered sprite table with a two-stage per-pixel hit/priority pipeline.
module sprite_scanner #(
  parameter int N_SPRITES   = sprite_pkg::N_SPRITES,
  parameter int SPRITE_SIZE = sprite_pkg::SPRITE_SIZE
) (
  input logic            clk,
  input logic            reset,
  sprite_scanner_if.slave bus
);
  import sprite_pkg::*;
  logic [31:0] r_shadow [N_SPRITES];
  logic [31:0] r_active [N_SPRITES];
  logic [N_SPRITES-1:0] w_hits, r_hits;
  logic [15:0] w_rom [N_SPRITES];
  logic [15:0] r_rom [N_SPRITES];
  logic r_v1, r_pix_valid, r_hit, w_hit;
  logic [2:0] r_idx, w_idx;
  logic [15:0] r_rom_addr;
  for (genvar k = 0; k < N_SPRITES; k++) begin : g_slot
    sprite_hit_test #(.SPRITE_SIZE(SPRITE_SIZE)) u_hit (
      .i_desc(r_active[k]),
      .i_px  (bus.pixel_x),
      .i_py  (bus.pixel_y),
      .o_hit (w_hits[k]),
      .o_rom (w_rom[k])
    );
  end
  // descending scan so the lowest hitting slot is the last to assign
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int k = N_SPRITES - 1; k >= 0; k--) begin
      w_hit = r_hits[k] ? 1'b1 : w_hit;
      w_idx = r_hits[k] ? 3'(k) : w_idx;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_SPRITES; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
        r_rom[k]    <= '0;
      end
      r_hits      <= '0;
      r_v1        <= 1'b0;
      r_pix_valid <= 1'b0;
      r_hit       <= 1'b0;
      r_idx       <= '0;
      r_rom_addr  <= '0;
    end else begin
      if (bus.frame_start)
        for (int k = 0; k < N_SPRITES; k++) r_active[k] <= r_shadow[k];
      if (bus.we) r_shadow[bus.addr] <= bus.dina;
      r_v1 <= bus.pixel_tick;
      if (bus.pixel_tick) begin
        r_hits <= bus.video_on ? w_hits : '0;
        for (int k = 0; k < N_SPRITES; k++) r_rom[k] <= w_rom[k];
      end
      r_pix_valid <= r_v1;
      if (r_v1) begin
        r_hit      <= w_hit;
        r_idx      <= w_idx;
        r_rom_addr <= w_hit ? r_rom[w_idx] : '0;
      end
    end
  end
  assign bus.pix_valid  = r_pix_valid;
  assign bus.sprite_hit = r_hit;
  assign bus.sprite_idx = r_idx;
  assign bus.rom_addr   = r_rom_addr;
endmodule

// File: tb/tb_sprite_scanner.sv
// tb_sprite_scanner: directed vector table plus hand sequences for double buffering, priority and reset.
module tb_sprite_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  sprite_scanner_if bus();
  sprite_scanner dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        von;
    logic        hit;
    logic [2:0]  idx;
    logic [15:0] rom;
    string       name;
  } vec_t;
  localparam int NV = 11;
  vec_t va [NV];
  int n_pass = 0;
  int n_total = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  function automatic logic [31:0] desc(logic v, logic f, logic [9:0] x, logic [9:0] y,
                                       logic [2:0] row, logic [2:0] col);
    return {v, 4'b0000, f, x, y, row, col};
  endfunction
  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic fs);
    @(negedge clk);
    bus.we = 1'b1; bus.addr = a; bus.dina = d; bus.frame_start = fs;
    @(negedge clk);
    bus.we = 1'b0; bus.frame_start = 1'b0;
  endtask
  task automatic fstart();
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask
  task automatic drive(input vec_t v);
    bus.pixel_tick = 1'b1; bus.pixel_x = v.x; bus.pixel_y = v.y; bus.video_on = v.von;
  endtask
  task automatic chk_out(input vec_t v);
    chk({v.name, " valid"}, bus.pix_valid, 1);
    chk({v.name, " hit"}, bus.sprite_hit, v.hit);
    chk({v.name, " idx"}, bus.sprite_idx, v.idx);
    chk({v.name, " rom"}, bus.rom_addr, v.rom);
  endtask
  task automatic tick_check(input vec_t v);
    @(negedge clk);
    drive(v);
    @(negedge clk);
    chk({v.name, " early"}, bus.pix_valid, 0);
    bus.pixel_tick = 1'b0;
    @(negedge clk);
    chk_out(v);
    @(negedge clk);
    chk({v.name, " pulse"}, bus.pix_valid, 0);
    chk({v.name, " hold"}, bus.rom_addr, v.rom);
  endtask
  initial begin
    vec_t t;
    logic seen;
    bus.we = 0; bus.addr = 0; bus.dina = 0; bus.frame_start = 0;
    bus.pixel_tick = 0; bus.pixel_x = 0; bus.pixel_y = 0; bus.video_on = 0;
    va[0]  = '{10'd80,   10'd350, 1'b1, 1'b1, 3'd0, 16'h0400, "base"};
    va[1]  = '{10'd111,  10'd381, 1'b1, 1'b1, 3'd0, 16'h07FF, "corner"};
    va[2]  = '{10'd112,  10'd350, 1'b1, 1'b0, 3'd0, 16'h0000, "right_out"};
    va[3]  = '{10'd79,   10'd350, 1'b1, 1'b0, 3'd0, 16'h0000, "left_out"};
    va[4]  = '{10'd80,   10'd382, 1'b1, 1'b0, 3'd0, 16'h0000, "below_out"};
    va[5]  = '{10'd80,   10'd350, 1'b0, 1'b0, 3'd0, 16'h0000, "video_off"};
    va[6]  = '{10'd405,  10'd100, 1'b1, 1'b1, 3'd3, 16'h201A, "hflip"};
    va[7]  = '{10'd5,    10'd0,   1'b1, 1'b0, 3'd0, 16'h0000, "no_wrap"};
    va[8]  = '{10'd1010, 10'd5,   1'b1, 1'b1, 3'd4, 16'hFCAA, "edge_in"};
    va[9]  = '{10'd1023, 10'd31,  1'b1, 1'b1, 3'd4, 16'hFFF7, "edge_max"};
    va[10] = '{10'd1023, 10'd32,  1'b1, 1'b0, 3'd0, 16'h0000, "edge_below"};
    #12;
    chk("rst valid", bus.pix_valid, 0);
    chk("rst hit", bus.sprite_hit, 0);
    chk("rst idx", bus.sprite_idx, 0);
    chk("rst rom", bus.rom_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    wr(3'd0, desc(1, 0, 80, 350, 0, 1), 0);
    wr(3'd3, desc(1, 1, 400, 100, 1, 0), 0);
    wr(3'd4, desc(1, 0, 1000, 0, 7, 7), 0);
    tick_check('{10'd80, 10'd350, 1'b1, 1'b0, 3'd0, 16'h0, "pre_frame"});
    fstart();
    for (int i = 0; i < NV; i++) tick_check(va[i]);
    for (int i = 0; i < NV + 2; i++) begin
      @(negedge clk);
      if (i >= 2) chk_out(va[i-2]);
      if (i < NV) drive(va[i]);
      else bus.pixel_tick = 1'b0;
    end
    @(negedge clk);
    chk("stream end", bus.pix_valid, 0);
    wr(3'd0, desc(1, 0, 200, 200, 0, 2), 0);
    tick_check('{10'd210, 10'd210, 1'b1, 1'b0, 3'd0, 16'h0, "shadow_only"});
    wr(3'd1, desc(1, 0, 600, 600, 3, 3), 1);
    tick_check('{10'd210, 10'd210, 1'b1, 1'b1, 3'd0, 16'h094A, "after_frame"});
    tick_check('{10'd605, 10'd610, 1'b1, 1'b0, 3'd0, 16'h0, "same_cycle_wr"});
    fstart();
    tick_check('{10'd605, 10'd610, 1'b1, 1'b1, 3'd1, 16'h6D45, "next_frame"});
    wr(3'd0, 32'h0, 0);
    wr(3'd1, 32'h0, 0);
    wr(3'd2, desc(1, 0, 90, 340, 2, 3), 0);
    wr(3'd5, desc(1, 0, 95, 355, 5, 6), 0);
    fstart();
    tick_check('{10'd100, 10'd360, 1'b1, 1'b1, 3'd2, 16'h4E8A, "prio_2"});
    wr(3'd2, desc(0, 0, 90, 340, 2, 3), 0);
    fstart();
    tick_check('{10'd100, 10'd360, 1'b1, 1'b1, 3'd5, 16'hB8A5, "prio_5"});
    t = '{10'd100, 10'd360, 1'b1, 1'b1, 3'd5, 16'hB8A5, "rst_stream"};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(t);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async valid", bus.pix_valid, 0);
    chk("async hit", bus.sprite_hit, 0);
    chk("async idx", bus.sprite_idx, 0);
    chk("async rom", bus.rom_addr, 0);
    @(negedge clk);
    bus.pixel_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | bus.pix_valid;
    end
    chk("no valid after rst", seen, 0);
    fstart();
    tick_check('{10'd100, 10'd360, 1'b1, 1'b0, 3'd0, 16'h0, "tables_cleared"});
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
